alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external combinational ALU through an IDLE/EXEC/RESP FSM.
// Optional define ALU_ARB_FIXED_PRIO_EN replaces round robin with fixed priority for requester 0.
module alu_arbiter #(
   parameter int W     = 32,
   parameter int CMD_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [CMD_W-1:0] cmd0,
   input  logic [CMD_W-1:0] cmd1,
   input  logic [W-1:0]     a0,
   input  logic [W-1:0]     a1,
   input  logic [W-1:0]     b0,
   input  logic [W-1:0]     b1,
   output logic             done0,
   output logic             done1,
   output logic [W-1:0]     result,
   output logic             err,
   output logic             busy,
   output logic [W-1:0]     alu_in1,
   output logic [W-1:0]     alu_in2,
   output logic [CMD_W-1:0] alu_cmd,
   input  logic [W-1:0]     alu_result
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic [CMD_W-1:0] lat_cmd;
   logic [W-1:0]     lat_a;
   logic [W-1:0]     lat_b;
   logic             lat_id;
   logic             gnt;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic             last;
`endif

   function automatic logic cmd_supported(input logic [CMD_W-1:0] c);
      logic ok;
      ok = 1'b0;
      case (c)
         CMD_W'(4'b0000), CMD_W'(4'b0010), CMD_W'(4'b0100),
         CMD_W'(4'b0101), CMD_W'(4'b0110), CMD_W'(4'b0111),
         CMD_W'(4'b1000), CMD_W'(4'b1001), CMD_W'(4'b1010): ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // gnt is the id of the winning requester; only meaningful when some request is high
   always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt = ~req0;
`else
      if (req0 && req1) gnt = ~last;
      else              gnt = req1;
`endif
   end

   // The shared ALU always sees the latched operation, so it is stable through EXEC
   assign alu_in1 = lat_a;
   assign alu_in2 = lat_b;
   assign alu_cmd = lat_cmd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         lat_cmd <= '0;
         lat_a   <= '0;
         lat_b   <= '0;
         lat_id  <= 1'b0;
         result  <= '0;
         err     <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         busy    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last    <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               err   <= 1'b0;
               if (req0 || req1) begin
                  lat_id  <= gnt;
                  lat_cmd <= gnt ? cmd1 : cmd0;
                  lat_a   <= gnt ? a1 : a0;
                  lat_b   <= gnt ? b1 : b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last    <= gnt;
`endif
                  busy    <= 1'b1;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               // Unsupported commands still complete, but report zero with err
               if (cmd_supported(lat_cmd)) begin
                  result <= alu_result;
                  err    <= 1'b0;
               end else begin
                  result <= '0;
                  err    <= 1'b1;
               end
               done0 <= ~lat_id;
               done1 <= lat_id;
               busy  <= 1'b1;
               state <= RESP;
            end
            RESP: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [3:0]  cmd0, cmd1;
   logic [31:0] a0, a1, b0, b1;
   logic        done0, done1, err, busy;
   logic [31:0] result, alu_in1, alu_in2, alu_result;
   logic [3:0]  alu_cmd;

   int checks = 0;
   int fails  = 0;
   bit last_m = 1'b1;

   alu_arbiter #(.W(32), .CMD_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
      .a0(a0), .a1(a1), .b0(b0), .b1(b1),
      .done0(done0), .done1(done1), .result(result), .err(err), .busy(busy),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd),
      .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      case (c)
         4'd0:    return x + y;
         4'd2:    return x - y;
         4'd4:    return x & y;
         4'd5:    return x | y;
         4'd6:    return x ^ y;
         4'd7:    return ~(x | y);
         4'd8:    return x << y[4:0];
         4'd9:    return 32'($signed(x) >>> y[4:0]);
         4'd10:   return x >> y[4:0];
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic bit supported(input logic [3:0] c);
      return (c inside {4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10});
   endfunction

   // Environment ALU driven by the arbiter
   assign alu_result = ref_alu(alu_cmd, alu_in1, alu_in2);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input bit r0, input bit r1,
                         input logic [3:0] c0, input logic [31:0] x0, input logic [31:0] y0,
                         input logic [3:0] c1, input logic [31:0] x1, input logic [31:0] y1);
      bit          win;
      logic [3:0]  cw;
      logic [31:0] xw, yw, exp_res;
      @(negedge clk);
      req0 = r0; req1 = r1;
      cmd0 = c0; a0 = x0; b0 = y0;
      cmd1 = c1; a1 = x1; b1 = y1;
      if (!r0 && !r1) begin
         @(posedge clk); #1;
         check("idle_busy", busy, 1'b0);
         return;
      end
`ifdef ALU_ARB_FIXED_PRIO_EN
      win = r0 ? 1'b0 : 1'b1;
`else
      win = (r0 && r1) ? ~last_m : r1;
`endif
      last_m = win;
      cw = win ? c1 : c0;
      xw = win ? x1 : x0;
      yw = win ? y1 : y0;
      exp_res = supported(cw) ? ref_alu(cw, xw, yw) : 32'd0;
      @(posedge clk); #1;
      check("exec_busy", busy, 1'b1);
      check("exec_done", {31'd0, done0 | done1}, 32'd0);
      check("exec_alu_in1", alu_in1, xw);
      check("exec_alu_cmd", {28'd0, alu_cmd}, {28'd0, cw});
      // Inputs change after the grant edge; requests stay high during EXEC
      cmd0 = 4'($urandom); a0 = $urandom; b0 = $urandom;
      cmd1 = 4'($urandom); a1 = $urandom; b1 = $urandom;
      @(posedge clk); #1;
      check("resp_done0", {31'd0, done0}, {31'd0, ~win});
      check("resp_done1", {31'd0, done1}, {31'd0, win});
      check("resp_result", result, exp_res);
      check("resp_err", {31'd0, err}, {31'd0, !supported(cw)});
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      check("idle_done", {30'd0, done1, done0}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("result_hold", result, exp_res);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {30'd0, done1, done0}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_alu_in1", alu_in1, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Contention with continuous re-requests
      for (int i = 0; i < 4; i++)
         run_op(1, 1, 4'd0, 32'd100 + 32'(i), 32'd1, 4'd2, 32'd200 + 32'(i), 32'd1);

      run_op(1, 0, 4'b0000, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0);
      run_op(0, 1, 4'd0, 32'd0, 32'd0, 4'b0010, 32'd10, 32'd3);
      run_op(1, 0, 4'b1111, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0);
      run_op(1, 0, 4'b1001, 32'h8000_0000, 32'd4, 4'd0, 32'd0, 32'd0);
      check("asr_value", result, 32'hF800_0000);

      // Reset while EXEC: nothing completes and arbitration history resets
      @(negedge clk);
      req0 = 1; cmd0 = 4'd0; a0 = 32'd1; b0 = 32'd1;
      @(posedge clk); #1;
      check("mid_busy", {31'd0, busy}, 32'd1);
      req0 = 0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_alu_in1", alu_in1, 32'd0);
      @(posedge clk); #1;
      check("mid_rst_done", {30'd0, done1, done0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_m = 1'b1;
      run_op(1, 1, 4'd5, 32'hF0, 32'h0F, 4'd6, 32'hFF, 32'h0F);

      for (int i = 0; i < 40; i++) begin
         bit rr0, rr1;
         rr0 = 1'($urandom);
         rr1 = 1'($urandom);
         run_op(rr0, rr1, 4'($urandom_range(0, 15)), $urandom, $urandom,
                4'($urandom_range(0, 15)), $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
